// File: rtl/apb_data_bridge.sv
// ----------------------------------------------------------------------------
// apb_data_bridge
//   Load/store bridge from the RV32I data-memory port onto an APB-style bus.
//   One request per transfer. Stores get byte strobes and lane-replicated
//   write data. Loads return PRDATA shifted so the addressed byte/half sits
//   at bit 0, which lets the datapath reuse its existing extension logic.
//   Misaligned requests and bus timeouts complete with ack+err.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   req/we/funct3     request strobe, direction, access width code
//   addr, wdata       byte address, width-trimmed store data
//   busy              high whenever the FSM is not IDLE
//   ack, err, rdata   one-cycle completion pulse, error flag, shifted load data
//   PSEL..PSTRB       registered APB master outputs
//   PRDATA, PREADY    APB slave response
// ----------------------------------------------------------------------------
module apb_data_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_ERR
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_off;
    logic            r_we;

    logic            w_is_b;
    logic            w_is_h;
    logic            w_misal;
    logic [3:0]      w_strb;
    logic [31:0]     w_pwdata;
    logic            w_start;
    logic            w_done;
    logic            w_tout;

    // Width decode of the incoming request. The unsigned load codes (100/101)
    // only mean byte/half for loads; every unlisted code is a word access.
    always_comb begin
        w_is_b   = (funct3 == 3'b000) || (!we && funct3 == 3'b100);
        w_is_h   = (funct3 == 3'b001) || (!we && funct3 == 3'b101);
        w_misal  = 1'b0;
        w_strb   = 4'b1111;
        w_pwdata = wdata;
        if (w_is_b) begin
            w_strb   = 4'b0001 << addr[1:0];
            w_pwdata = {4{wdata[7:0]}};
        end else if (w_is_h) begin
            w_misal  = addr[0];
            w_strb   = 4'b0011 << addr[1:0];
            w_pwdata = {2{wdata[15:0]}};
        end else begin
            w_misal  = (addr[1:0] != 2'b00);
        end
        if (!we) begin
            w_strb = 4'b0000;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_tout      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_start     = !w_misal;
                    w_state_nxt = w_misal ? S_ERR : S_SETUP;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                // PREADY wins over the timeout on the final allowed cycle.
                if (PREADY) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_tout      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_off   <= 2'b00;
            r_we    <= 1'b0;
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
            PSTRB   <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            // ack lands in the IDLE cycle that follows completion
            ack     <= w_done | w_tout | (r_state == S_ERR);
            err     <= w_tout | (r_state == S_ERR);

            if (w_start) begin
                PSEL    <= 1'b1;
                PENABLE <= 1'b0;
                PWRITE  <= we;
                PADDR   <= {addr[31:2], 2'b00};
                PWDATA  <= w_pwdata;
                PSTRB   <= w_strb;
                r_off   <= addr[1:0];
                r_we    <= we;
                r_cnt   <= '0;
            end

            if (r_state == S_SETUP) begin
                PENABLE <= 1'b1;
            end

            if (r_state == S_ACCESS) begin
                if (w_done || w_tout) begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            // Loads only; a store or error leaves the last load result visible.
            if (w_done && !r_we) begin
                rdata <= PRDATA >> {r_off, 3'b000};
            end
        end
    end

    assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_apb_data_bridge.sv
module tb_apb_data_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, ack, err;
    logic [31:0] rdata;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    apb_data_bridge #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .ack(ack), .err(err),
        .rdata(rdata), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;   // PREADY-low ACCESS cycles, -1 = never ready
        int          lat;     // edge (after N) at which ack is sampled high
        logic        err;
        logic [3:0]  strb;
        logic [31:0] pwdata;
        logic        chk_rd;
        logic [31:0] rd;
        int          psel;    // number of cycles PSEL is high
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    // Issue one request at the current negedge and act as the APB slave until
    // ack is seen (or a cycle bound expires). Returns at the ack negedge so a
    // following call issues its request in the ack cycle.
    task automatic run_xfer(input string nm, input logic i_we, input logic [2:0] i_f3,
                            input logic [31:0] i_addr, input logic [31:0] i_wdata,
                            input logic [31:0] i_prdata, input int waits,
                            input int e_lat, input logic e_err, input logic [3:0] e_strb,
                            input logic [31:0] e_pwdata, input logic chk_rd,
                            input logic [31:0] e_rd, input int e_psel);
        int k = 0;
        int acc = 0;
        int psel_n = 0;
        int ack_k = -1;
        int bad = 0;
        logic busy1 = 1'b0;
        logic got_err = 1'b0;
        logic got_psel = 1'b0;
        logic [31:0] got_rd = '0;
        logic [31:0] e_paddr;
        e_paddr = {i_addr[31:2], 2'b00};
        req = 1'b1; we = i_we; funct3 = i_f3; addr = i_addr; wdata = i_wdata;
        PREADY = 1'b0;
        @(posedge clk);
        while (ack_k < 0 && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) busy1 = busy;
            if (PSEL) begin
                psel_n++;
                if (PADDR !== e_paddr || PSTRB !== e_strb || PWRITE !== i_we) bad++;
                if (i_we && PWDATA !== e_pwdata) bad++;
                if (PENABLE !== (psel_n > 1)) bad++;
            end
            if (ack) begin
                ack_k = k; got_err = err; got_rd = rdata; got_psel = PSEL;
            end
            // garbage requests while busy must be ignored
            if (busy) begin
                req = 1'(($urandom & 1)); we = 1'($urandom & 1);
                funct3 = 3'($urandom & 7); addr = $urandom; wdata = $urandom;
            end else begin
                req = 1'b0;
            end
            if (PSEL && PENABLE) begin
                acc++;
                PREADY = (waits >= 0) && (acc > waits);
                PRDATA = PREADY ? i_prdata : $urandom;
            end else begin
                PREADY = 1'b0;
                PRDATA = $urandom;
            end
        end
        req = 1'b0;
        chk({nm, ".ack_latency"}, ack_k, e_lat);
        chk({nm, ".err"}, {31'd0, got_err}, {31'd0, e_err});
        chk({nm, ".busy"}, {31'd0, busy1}, 32'd1);
        chk({nm, ".psel_cycles"}, psel_n, e_psel);
        chk({nm, ".bus_fields"}, bad, 0);
        chk({nm, ".psel_at_ack"}, {31'd0, got_psel}, 32'd0);
        if (chk_rd) chk({nm, ".rdata"}, got_rd, e_rd);
    endtask

    initial begin
        logic [31:0] model_rd;

        //           we    f3      addr          wdata         prdata        w  lat err strb     pwdata        chk  rd           psel
        tbl[0]  = '{1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 32'h0,        0,  3, 1'b0, 4'b1000, 32'hABAB_ABAB, 1'b0, 32'h0,        2};
        tbl[1]  = '{1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h8001_1234, 0,  3, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0000_8001, 2};
        tbl[2]  = '{1'b0, 3'b010, 32'h0000_3000, 32'h0,        32'hDEAD_BEEF, 3,  6, 1'b0, 4'b0000, 32'h0,        1'b1, 32'hDEAD_BEEF, 5};
        tbl[3]  = '{1'b1, 3'b010, 32'h0000_4001, 32'h1111_2222, 32'h0,        0,  2, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0,        0};
        tbl[4]  = '{1'b0, 3'b001, 32'h0000_4001, 32'h0,        32'h0,        0,  2, 1'b1, 4'b0000, 32'h0,        1'b1, 32'hDEAD_BEEF, 0};
        tbl[5]  = '{1'b0, 3'b010, 32'h0000_5000, 32'h0,        32'h1234_5678, -1, 18, 1'b1, 4'b0000, 32'h0,        1'b1, 32'hDEAD_BEEF, 17};
        tbl[6]  = '{1'b1, 3'b001, 32'h0000_6002, 32'h0000_BEEF, 32'h0,        0,  3, 1'b0, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0,        2};
        tbl[7]  = '{1'b0, 3'b100, 32'h0000_7001, 32'h0,        32'h1122_3344, 0,  3, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0011_2233, 2};
        tbl[8]  = '{1'b1, 3'b000, 32'h0000_8000, 32'h0000_005A, 32'h0,        1,  4, 1'b0, 4'b0001, 32'h5A5A_5A5A, 1'b0, 32'h0,        3};
        tbl[9]  = '{1'b1, 3'b011, 32'h0000_9000, 32'hCAFE_F00D, 32'h0,        0,  3, 1'b0, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,        2};
        tbl[10] = '{1'b0, 3'b110, 32'h0000_9002, 32'h0,        32'h0,        0,  2, 1'b1, 4'b0000, 32'h0,        1'b1, 32'h0011_2233, 0};
        tbl[11] = '{1'b0, 3'b101, 32'h0000_A001, 32'h0,        32'h0,        0,  2, 1'b1, 4'b0000, 32'h0,        1'b1, 32'h0011_2233, 0};
        tbl[12] = '{1'b0, 3'b000, 32'h0000_B003, 32'h0,        32'hA500_0000, 0,  3, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h0000_00A5, 2};
        tbl[13] = '{1'b1, 3'b001, 32'h0000_C000, 32'h0000_7777, 32'h0,        2,  5, 1'b0, 4'b0011, 32'h7777_7777, 1'b0, 32'h0,        4};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.ctrl", {26'd0, busy, ack, err, PSEL, PENABLE, PWRITE}, 32'd0);
        chk("reset.paddr", PADDR, 32'd0);
        chk("reset.pwdata", PWDATA, 32'd0);
        chk("reset.pstrb", {28'd0, PSTRB}, 32'd0);
        chk("reset.rdata", rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // directed table, issued back to back
        for (int i = 0; i < 14; i++) begin
            run_xfer($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata,
                     tbl[i].prdata, tbl[i].waits, tbl[i].lat, tbl[i].err, tbl[i].strb,
                     tbl[i].pwdata, tbl[i].chk_rd, tbl[i].rd, tbl[i].psel);
        end

        // randomized transactions against a byte-level reference model
        model_rd = 32'h0000_00A5;
        for (int n = 0; n < 150; n++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr, r_wd, r_pd, e_pw, e_rd;
            logic [3:0]  e_st;
            int          sz, off, w, lat, ps;
            logic        mis, e_er;
            r_we   = 1'($urandom & 1);
            r_f3   = 3'($urandom & 7);
            r_addr = $urandom;
            r_wd   = $urandom;
            r_pd   = $urandom;
            w      = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            if (r_f3 == 3'd0 || (!r_we && r_f3 == 3'd4)) sz = 1;
            else if (r_f3 == 3'd1 || (!r_we && r_f3 == 3'd5)) sz = 2;
            else sz = 4;
            off = int'(r_addr % 4);
            mis = (off % sz) != 0;
            e_st = r_we ? 4'(((1 << sz) - 1) << off) : 4'b0000;
            if (sz == 1) e_pw = r_wd[7:0] * 32'h0101_0101;
            else if (sz == 2) e_pw = r_wd[15:0] * 32'h0001_0001;
            else e_pw = r_wd;
            if (mis) begin lat = 2; ps = 0; e_er = 1'b1; end
            else if (w < 0) begin lat = 18; ps = 17; e_er = 1'b1; end
            else begin lat = 3 + w; ps = 2 + w; e_er = 1'b0; end
            e_rd = (!r_we && !e_er) ? (r_pd >> (8 * off)) : model_rd;
            run_xfer($sformatf("rnd%0d", n), r_we, r_f3, r_addr, r_wd, r_pd, w, lat, e_er,
                     e_st, e_pw, !r_we, e_rd, ps);
            if (!r_we) model_rd = e_rd;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // reset during ACCESS aborts without ack
        begin
            int k = 0;
            req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h0000_3000; PREADY = 1'b0;
            @(posedge clk);
            @(negedge clk);
            req = 1'b0;
            while (!(PSEL && PENABLE) && k < 5) begin
                @(negedge clk);
                k++;
            end
            chk("rst_mid.in_access", {31'd0, PSEL & PENABLE}, 32'd1);
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rst_mid.psel", {31'd0, PSEL}, 32'd0);
            chk("rst_mid.busy", {31'd0, busy}, 32'd0);
            chk("rst_mid.ack", {31'd0, ack}, 32'd0);
            chk("rst_mid.rdata", rdata, 32'd0);
            reset = 1'b0;
            @(negedge clk);
            chk("rst_mid.no_late_ack", {31'd0, ack}, 32'd0);
            run_xfer("post_rst_sb", 1'b1, 3'b000, 32'h0000_1000, 32'h0000_005A, 32'h0, 0,
                     3, 1'b0, 4'b0001, 32'h5A5A_5A5A, 1'b0, 32'h0, 2);
            // immediately back to back: load issued in the ack cycle
            run_xfer("b2b_lb", 1'b0, 3'b000, 32'h0000_1002, 32'h0, 32'h00C3_0000, 0,
                     3, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0000_00C3, 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
